// File: rtl/masked_sbox_layer_seq.sv
// Sequencer that streams one PRINCE S-box layer, nibble by nibble, through a shared
// pipelined 3-share masked S-box core. Optional input remasking: MASKED_SBOX_REFRESH_EN.
module masked_sbox_layer_seq #(
    parameter int NIBBLES  = 16,
    parameter int SBOX_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   inv,
    input  logic [4*NIBBLES-1:0]   sh_a_in,
    input  logic [4*NIBBLES-1:0]   sh_b_in,
    input  logic [4*NIBBLES-1:0]   sh_c_in,
    output logic [4*NIBBLES-1:0]   sh_a_out,
    output logic [4*NIBBLES-1:0]   sh_b_out,
    output logic [4*NIBBLES-1:0]   sh_c_out,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             sbox_in_a,
    output logic [3:0]             sbox_in_b,
    output logic [3:0]             sbox_in_c,
    output logic                   sbox_inv,
    output logic [SBOX_LAT-1:0]    sbox_en,
    input  logic [3:0]             sbox_out_a,
    input  logic [3:0]             sbox_out_b,
    input  logic [3:0]             sbox_out_c
`ifdef MASKED_SBOX_REFRESH_EN
    ,
    input  logic [7:0]             rnd_in,
    input  logic                   rnd_valid,
    output logic                   rnd_ready
`endif
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int CW = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [IW-1:0]         issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]         col_cnt_q, col_cnt_d;
    logic [SBOX_LAT-1:0]   valid_sr_q, valid_sr_d;
    logic [W-1:0]          lat_a_q, lat_b_q, lat_c_q;
    logic                  inv_q;
    logic [W-1:0]          out_a_q, out_b_q, out_c_q;
    logic [W-1:0]          out_a_d, out_b_d, out_c_d;

    logic                  load;
    logic                  active;
    logic                  advance;
    logic                  issue;
    logic                  capture;
    logic [3:0]            nib_a, nib_b, nib_c;

    assign active = (state_q == FEED) || (state_q == DRAIN);

`ifdef MASKED_SBOX_REFRESH_EN
    // Without fresh randomness the whole pipeline freezes, core stages included.
    assign advance   = !active || rnd_valid;
    assign rnd_ready = (state_q == FEED);
`else
    assign advance   = 1'b1;
`endif

    assign load    = (state_q == IDLE) && start;
    assign issue   = (state_q == FEED) && advance;
    assign capture = active && advance && valid_sr_q[SBOX_LAT-1];

    always_comb begin
        nib_a = lat_a_q[4*issue_cnt_q +: 4];
        nib_b = lat_b_q[4*issue_cnt_q +: 4];
        nib_c = lat_c_q[4*issue_cnt_q +: 4];
`ifdef MASKED_SBOX_REFRESH_EN
        nib_a = nib_a ^ rnd_in[3:0];
        nib_b = nib_b ^ rnd_in[7:4];
        nib_c = nib_c ^ rnd_in[3:0] ^ rnd_in[7:4];
`endif
    end

    assign sbox_in_a = (state_q == FEED) ? nib_a : 4'h0;
    assign sbox_in_b = (state_q == FEED) ? nib_b : 4'h0;
    assign sbox_in_c = (state_q == FEED) ? nib_c : 4'h0;
    assign sbox_inv  = inv_q;

    // Stage k of the core only clocks when a valid nibble is about to enter it.
    generate
        for (genvar gi = 0; gi < SBOX_LAT; gi++) begin : g_en
            if (gi == 0) begin : g_first
                assign sbox_en[gi] = issue;
            end else begin : g_rest
                assign sbox_en[gi] = active && advance && valid_sr_q[gi-1];
            end
        end
    endgenerate

    assign busy     = active;
    assign done     = (state_q == FIN);
    assign sh_a_out = out_a_q;
    assign sh_b_out = out_b_q;
    assign sh_c_out = out_c_q;

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        col_cnt_d   = col_cnt_q;
        valid_sr_d  = valid_sr_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_c_d     = out_c_q;

        if (active && advance) begin
            valid_sr_d    = valid_sr_q << 1;
            valid_sr_d[0] = issue;
        end

        if (capture) begin
            out_a_d[4*col_cnt_q +: 4] = sbox_out_a;
            out_b_d[4*col_cnt_q +: 4] = sbox_out_b;
            out_c_d[4*col_cnt_q +: 4] = sbox_out_c;
            col_cnt_d                 = col_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = FEED;
                    issue_cnt_d = '0;
                    col_cnt_d   = '0;
                    valid_sr_d  = '0;
                end
            end
            FEED: begin
                if (issue) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == IW'(NIBBLES - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (capture && (col_cnt_q == CW'(NIBBLES - 1))) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            col_cnt_q   <= '0;
            valid_sr_q  <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_c_q     <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            col_cnt_q   <= col_cnt_d;
            valid_sr_q  <= valid_sr_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_c_q     <= out_c_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_a_q <= '0;
            lat_b_q <= '0;
            lat_c_q <= '0;
            inv_q   <= 1'b0;
        end else if (load) begin
            lat_a_q <= sh_a_in;
            lat_b_q <= sh_b_in;
            lat_c_q <= sh_c_in;
            inv_q   <= inv;
        end
    end

endmodule
